// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx
//
// UART receiver for 8N1 frames (optionally 8E1). The asynchronous serial line
// is synchronised and then sampled on the oversampling tick from the baud
// generator. Each received byte lands in a single-entry holding register and
// is handed over through a valid/ready pair. While a frame is being received
// rx_busy_o is raised so the baud generator does not change its divisor.
//
// Build option:
//   UART_RX_PARITY_EN  - when defined, frames carry one even-parity bit after
//                        the data bits and parity_err_o reports a mismatch.
//                        When undefined, there is no parity bit and
//                        parity_err_o is constant 0.
//
// Parameters:
//   OverSampleRate - baud ticks per bit period (even, >= 4)
//   DataBits       - data bits per frame, LSB first (5..8)
//
// Ports:
//   clk_i        in   system clock
//   rst_ni       in   asynchronous active-low reset
//   baud_tick_i  in   one-cycle pulse, OverSampleRate pulses per bit
//   rx_i         in   asynchronous serial line, idle high
//   rx_ready_i   in   consumer accepts the held byte
//   rx_data_o    out  received byte
//   rx_valid_o   out  holding register is full
//   frame_err_o  out  stop bit of the held byte was sampled as 0
//   parity_err_o out  parity mismatch for the held byte
//   overrun_o    out  one-cycle pulse: a completed frame was dropped
//   rx_busy_o    out  a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int OverSampleRate = 16,
    parameter int DataBits       = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                baud_tick_i,
    input  logic                rx_i,
    input  logic                rx_ready_i,
    output logic [DataBits-1:0] rx_data_o,
    output logic                rx_valid_o,
    output logic                frame_err_o,
    output logic                parity_err_o,
    output logic                overrun_o,
    output logic                rx_busy_o
);

    localparam int CW = $clog2(OverSampleRate);
    localparam int BW = (DataBits > 1) ? $clog2(DataBits) : 1;

    // Start bit is checked half a bit after the edge; all later bits one full
    // bit period apart, which places every sample near mid-bit.
    localparam logic [CW-1:0] HALF_LAST = CW'(OverSampleRate / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OverSampleRate - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DataBits - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser; resets to the idle line level so that reset
    // release never looks like a start edge.
    // -------------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic       rx_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx_i};
        end
    end

    assign rx_s = sync_reg[1];

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t                state_reg,    state_next;
    logic [CW-1:0]         cnt_reg,      cnt_next;
    logic [BW-1:0]         bit_cnt_reg,  bit_cnt_next;
    logic [DataBits-1:0]   shift_reg,    shift_next;
    logic [DataBits-1:0]   data_reg,     data_next;
    logic                  valid_reg,    valid_next;
    logic                  ferr_reg,     ferr_next;
    logic                  overrun_reg,  overrun_next;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit_reg,  par_bit_next;
    logic                  perr_reg,     perr_next;
`endif

    logic frame_done;
    logic accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            overrun_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_reg <= 1'b0;
            perr_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            ferr_reg    <= ferr_next;
            overrun_reg <= overrun_next;
`ifdef UART_RX_PARITY_EN
            par_bit_reg <= par_bit_next;
            perr_reg    <= perr_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        valid_next   = valid_reg;
        ferr_next    = ferr_reg;
        overrun_next = 1'b0;
        frame_done   = 1'b0;
        accept       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_next = par_bit_reg;
        perr_next    = perr_reg;
`endif

        // Consumer handshake; a frame completing in the same cycle reloads
        // valid below, so the later assignment wins.
        if (valid_reg && rx_ready_i) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                // Start edge is acted on immediately, not on a tick, so the
                // quantisation error is at most one tick.
                if (!rx_s) begin
                    state_next = ST_START;
                    cnt_next   = '0;
                end
            end

            ST_START: begin
                if (baud_tick_i) begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_next     = '0;
                        bit_cnt_next = '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state_next   = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (baud_tick_i) begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_next     = '0;
                        // LSB arrives first, so shift in at the top and move
                        // right; after DataBits samples bit 0 sits at bit 0.
                        shift_next   = {rx_s, shift_reg[DataBits-1:1]};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick_i) begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_next     = '0;
                        par_bit_next = rx_s;
                        state_next   = ST_STOP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
`endif

            ST_STOP: begin
                if (baud_tick_i) begin
                    if (cnt_reg == BIT_LAST) begin
                        // Leaving at mid stop bit lets the next start edge be
                        // caught during the second half of this bit.
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Frame completion: load the holding register if it is empty or being
        // drained this cycle, otherwise drop the frame and flag the overrun.
        if (frame_done) begin
            accept = !valid_reg || rx_ready_i;
            if (accept) begin
                data_next  = shift_reg;
                ferr_next  = !rx_s;
                valid_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                // Even parity: data bits plus parity bit must XOR to zero.
                perr_next  = (^shift_reg) != par_bit_reg;
`endif
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rx_data_o   = data_reg;
    assign rx_valid_o  = valid_reg;
    assign frame_err_o = ferr_reg;
    assign overrun_o   = overrun_reg;
    assign rx_busy_o   = (state_reg != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_reg;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx. Baud ticks arrive every 27 clocks (one bit =
// 432 clocks). Frames are launched aligned to a tick so every sample point is
// known exactly; expected bytes go into a scoreboard queue when a frame is
// driven and are popped when the byte is delivered.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OSR      = 16;
    localparam int DB       = 8;
    localparam int TICK_DIV = 27;
    localparam int BIT_CLKS = OSR * TICK_DIV;
    localparam int MID      = BIT_CLKS / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          baud_tick = 1'b0;
    logic          rx = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          rx_busy;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t sb_q[$];
    int   compared      = 0;
    int   mismatched    = 0;
    int   overrun_count = 0;
    int   overrun_base  = 0;

    uart_rx #(
        .OverSampleRate(OSR),
        .DataBits      (DB)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .baud_tick_i (baud_tick),
        .rx_i        (rx),
        .rx_ready_i  (rx_ready),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .frame_err_o (frame_err),
        .parity_err_o(parity_err),
        .overrun_o   (overrun),
        .rx_busy_o   (rx_busy)
    );

    always #5 clk = ~clk;

    // One-cycle tick every TICK_DIV clocks, changed 1 ns after the edge.
    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(posedge clk);
            #1 baud_tick = 1'b1;
            @(posedge clk);
            #1 baud_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (overrun === 1'b1) overrun_count++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and land 1 ns after the last one.
    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align_to_tick();
        @(posedge clk);
        while (baud_tick !== 1'b1) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic f, input logic p);
        exp_t e;
        e.data = d;
        e.ferr = f;
        e.perr = p;
        sb_q.push_back(e);
    endtask

    // Drives one complete frame. For stop=0 the line returns high right after
    // the stop sample point. pulse_ready raises rx_ready for exactly the cycle
    // in which the stop bit is sampled.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_flip, input logic pulse_ready);
        align_to_tick();
        rx = 1'b0;
        hold(2);
        check("busy_latency_2clk", rx_busy, 1'b0);
        hold(1);
        check("busy_latency_3clk", rx_busy, 1'b1);
        hold(BIT_CLKS - 3);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            hold(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        hold(BIT_CLKS);
`endif
        rx = stop;
        hold(MID - 1);
        if (pulse_ready) rx_ready = 1'b1;
        hold(1);
        if (pulse_ready) rx_ready = 1'b0;
        rx = 1'b1;
        hold(BIT_CLKS - MID);
        if (par_flip === 1'bx) rx = 1'b1;
    endtask

    task automatic check_delivery(input string tag);
        exp_t e;
        e = sb_q.pop_front();
        check({tag, "_valid"}, rx_valid, 1'b1);
        check({tag, "_data"}, rx_data, e.data);
        check({tag, "_frame_err"}, frame_err, e.ferr);
        check({tag, "_parity_err"}, parity_err, e.perr);
        $display("frame %s: data=0x%02h ferr=%0b perr=%0b", tag, rx_data, frame_err, parity_err);
    endtask

    task automatic consume(input string tag);
        rx_ready = 1'b1;
        hold(1);
        rx_ready = 1'b0;
        check({tag, "_consumed"}, rx_valid, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 4 * BIT_CLKS && rx_busy === 1'b1; i++) hold(1);
        check({tag, "_idle"}, rx_busy, 1'b0);
    endtask

    initial begin
        // Reset values
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        hold(5);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        rst_n = 1'b1;
        hold(3);

        // Clean frame, then a one-cycle consume
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check_delivery("a5");
        consume("a5");
        check("a5_data_kept", rx_data, 8'hA5);

        // Short low glitch: start-bit check at the 8th tick sees the line high
        align_to_tick();
        rx = 1'b0;
        hold(100);
        rx = 1'b1;
        check("glitch_busy_on", rx_busy, 1'b1);
        hold(MID - 101);
        check("glitch_busy_before_sample", rx_busy, 1'b1);
        hold(1);
        check("glitch_busy_off", rx_busy, 1'b0);
        check("glitch_no_valid", rx_valid, 1'b0);
        $display("glitch: busy dropped after start-bit check, valid=%0b", rx_valid);

        // Framing error is delivered, then reception carries on
        push_exp(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_delivery("3c_bad_stop");
        consume("3c");
        wait_idle("after_bad_stop");
        push_exp(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        check_delivery("55");
        consume("55");

        // Overrun: second frame dropped while the first is still held
        overrun_base = overrun_count;
        push_exp(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        check_delivery("11_first");
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        check("overrun_data_kept", rx_data, 8'h11);
        check("overrun_valid_kept", rx_valid, 1'b1);
        check("overrun_pulses", overrun_count, overrun_base + 1);
        $display("overrun: data=0x%02h pulses=%0d", rx_data, overrun_count - overrun_base);
        consume("11");

        // Consume in the very cycle the next frame completes: no overrun
        push_exp(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        check_delivery("11_second");
        push_exp(8'h22, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1);
        check_delivery("22_simultaneous");
        check("simultaneous_no_overrun", overrun_count, overrun_base + 1);

        // Reset during data bit 3 of 0xFF, with 0x22 still held
        align_to_tick();
        rx = 1'b0;
        hold(BIT_CLKS);
        rx = 1'b1;
        hold(3 * BIT_CLKS + 200);
        check("midframe_busy", rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_data", rx_data, 8'h00);
        check("midrst_valid", rx_valid, 1'b0);
        check("midrst_ferr", frame_err, 1'b0);
        check("midrst_perr", parity_err, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        check("midrst_busy", rx_busy, 1'b0);
        $display("reset mid-frame: data=0x%02h valid=%0b busy=%0b", rx_data, rx_valid, rx_busy);
        hold(5);
        rst_n = 1'b1;
        hold(3);
        push_exp(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        check_delivery("81_after_reset");
        consume("81");

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit is 1
        push_exp(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        check_delivery("07_parity_ok");
        consume("07_ok");
        push_exp(8'h07, 1'b0, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        check_delivery("07_parity_bad");
        consume("07_bad");
`endif

        check("final_overrun_total", overrun_count, overrun_base + 1);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
